vram_sched: RTL
===============

# vram_sched

Sequencer and arbiter for the 16-bit asynchronous VRAM SRAM. It shares the chip between two requesters:
- the display refill path, which issues short sequential read bursts and has priority;
- the GPU, which issues single-word reads and writes.

It owns every SRAM strobe, the address bus and the DQ output-enable. The top level only wires the tri-state buffer (`SRAM_DQ = sram_dq_oe ? sram_dq_out : 'z`).

## Interface

Parameters:
- `ADDR_W`, 19: word address width for VRAM.
- `BURST_MAX`, 16: maximum display burst length in words.
- `GUARD_WORDS`, 4: display words issued before a pending GPU access may be interleaved.

Ports (clock and reset first):
- `clk`  in  1: system clock; all logic is on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `disp_req`  in  1: display burst request, sampled only in `IDLE`.
- `disp_addr`  in  `ADDR_W`: burst start word address.
- `disp_len`  in  5: burst length in words, 1..`BURST_MAX`.
- `disp_data`  out  16: read word, valid while `disp_valid` is high.
- `disp_valid`  out  1: one-cycle pulse per returned display word.
- `disp_done`  out  1: one-cycle pulse marking the end of a burst.
- `gpu_re`  in  1: GPU read request, level, held until `gpu_rdy`.
- `gpu_we`  in  1: GPU write request, level, held until `gpu_rdy`.
- `gpu_addr`  in  `ADDR_W`: GPU word address.
- `gpu_wdata`  in  16: GPU write data.
- `gpu_rdata`  out  16: GPU read data, valid with `gpu_rdy`.
- `gpu_rdy`  out  1: one-cycle completion pulse for a GPU access.
- `sram_addr`  out  20: SRAM address, driven as `{1'b0, addr}`.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n`  out  1 each: SRAM strobes.
- `sram_dq_out`  out  16: write data to the pad.
- `sram_dq_in`  in  16: read data from the pad.
- `sram_dq_oe`  out  1: pad output enable.

## Operation

States:
- `IDLE`
- `RD_A`: address out, `sram_ce_n=0`, `sram_oe_n=0`.
- `RD_S`: strobes held; `sram_dq_in` sampled at the end of the cycle.
- `WR_A`: address and data out, `sram_dq_oe=1`, `sram_we_n=1`.
- `WR_P`: `sram_we_n=0`.
- `WR_H`: `sram_we_n=1`; address, data and `sram_dq_oe` held.

Strobe rules:
- `sram_lb_n` and `sram_ub_n` are 0 in every non-`IDLE` state.
- In `IDLE` all strobes are 1 and `sram_dq_oe=0`.

Arbitration in `IDLE`:
- `disp_req` beats GPU.
- `disp_req` with `disp_len==0` or `disp_len>BURST_MAX` is dropped: `disp_done` pulses the next cycle and no SRAM access is made.
- A GPU request with both `gpu_re` and `gpu_we` high is treated as a write.

Display burst:
- Start address and length are latched on grant.
- Words are read back-to-back as `RD_A`, `RD_S` pairs.
- The address increments by 1 per word and wraps modulo 2^`ADDR_W`.
- The remaining-word counter decrements on each `RD_S`.
- The cycle after each display `RD_S`, `disp_valid` pulses with the registered sample on `disp_data`.
- `disp_done` pulses in the same cycle as the last `disp_valid`.

GPU access:
- One read (`RD_A`, `RD_S`) or one write (`WR_A`, `WR_P`, `WR_H`), then return to `IDLE` or resume the interrupted burst.
- Reads: `gpu_rdy` pulses, with `gpu_rdata` valid, the cycle after `RD_S`.
- Writes: `gpu_rdy` pulses during `WR_H`.

Reset:
- Asserting `rst_n` low at any time, including mid-burst, forces `IDLE`.
- The outstanding burst is abandoned and produces no `disp_done`.
- All strobes go to 1, `sram_dq_oe`, `disp_valid`, `disp_done` and `gpu_rdy` go to 0, and the data outputs, `sram_addr` and all counters go to 0.

## Timing

- GPU read: request high in `IDLE` at cycle N, then `RD_A` at N+1, `RD_S` at N+2, `gpu_rdy` at N+3. Latency is 3 cycles.
- GPU write: `WR_A` at N+1, `WR_P` at N+2, `WR_H` with `gpu_rdy` at N+3. The next access may start at N+4.
- Display burst granted at N: the first `disp_valid` is at N+3, then one word every 2 cycles. A burst of L words ends at N+1+2L.
- `disp_valid` / `gpu_rdy` of the previous word overlap the next access's `RD_A`; there are no bubbles.
- Bus turnaround: a read following a write starts only after `WR_H`, so DQ is never driven while `sram_oe_n=0`.
- `gpu_rdy` is a single pulse. The GPU must drop or change its request in the cycle after `gpu_rdy`; a request still high then is treated as a new access.

## Configuration

Macro: `VRAM_SCHED_STARVE_GUARD_EN`.
- Defined: after every `GUARD_WORDS` display words of one burst, if a GPU request is pending, exactly one GPU access is inserted before the next display `RD_A`, and the burst then resumes at the next address. Worst-case GPU wait is `2*GUARD_WORDS+2` cycles.
- Undefined: display bursts always run to completion, and GPU requests are served only from `IDLE`. Worst-case GPU wait is `2*BURST_MAX+2` cycles.

## Test plan

- Reset mid-burst: hold `rst_n=0` during the 3rd word of a 16-word burst. Required: all strobes 1, `sram_dq_oe=0`, no `disp_done`; the next request starts cleanly from `IDLE`.
- Single GPU write then read: write 0xBEEF to 0x01234, then read 0x01234 from the SRAM model. Required: `gpu_rdy` at N+3 for both accesses, `gpu_rdata=0xBEEF`, and `sram_we_n` low only in `WR_P`.
- Display burst: `disp_addr=0x7FFFE`, `disp_len=4`. Required: reads of 0x7FFFE, 0x7FFFF, 0x00000, 0x00001 (wrap); `disp_valid` at N+3, N+5, N+7, N+9; `disp_done` at N+9.
- Simultaneous request: `disp_req` and `gpu_re` high in the same `IDLE` cycle with `disp_len=2`. Required: display served first; `gpu_rdy` 2 cycles after `disp_done`.
- Guard enabled: 16-word burst with `gpu_we` rising at word 1. Required: the write is inserted after word 4, `gpu_rdy` arrives before the 5th `disp_valid`, and the burst then continues at address start+4. With the guard disabled: `gpu_rdy` arrives only after `disp_done`.
- Invalid length: `disp_len=0` and then `disp_len=17`. Required: `disp_done` the next cycle with no SRAM strobe activity.

Source files
------------

// File: rtl/vram_sched.sv
// vram_sched: VRAM SRAM sequencer arbitrating display read bursts (priority) against single GPU accesses.
// Build option VRAM_SCHED_STARVE_GUARD_EN interleaves one pending GPU access every GUARD_WORDS burst words.
module vram_sched #(
    parameter int ADDR_W      = 19,
    parameter int BURST_MAX   = 16,
    parameter int GUARD_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic [4:0]        disp_len,
    output logic [15:0]       disp_data,
    output logic              disp_valid,
    output logic              disp_done,
    input  logic              gpu_re,
    input  logic              gpu_we,
    input  logic [ADDR_W-1:0] gpu_addr,
    input  logic [15:0]       gpu_wdata,
    output logic [15:0]       gpu_rdata,
    output logic              gpu_rdy,
    output logic [19:0]       sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n,
    output logic [15:0]       sram_dq_out,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_dq_oe
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_S, WR_A, WR_P, WR_H} state_t;
    localparam int GC_W = $clog2(GUARD_WORDS + 1);
`ifdef VRAM_SCHED_STARVE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, dptr_q, dptr_d, dsrc;
    logic [4:0]        rem_q, rem_d;
    logic [GC_W-1:0]   gcnt_q, gcnt_d;
    logic              gpu_acc_q, gpu_acc_d;
    logic [15:0]       wdata_q, wdata_d, disp_data_q, gpu_rdata_q;
    logic              disp_valid_q, disp_done_q, gpu_rdy_q;
    logic              gpu_pend, len_ok, grant, last_word, gcnt_wrap, guard_hit;
    logic              start, rd_disp, rd_gpu, burst_left;

    // a request still high in the gpu_rdy cycle belongs to the access just finished
    assign gpu_pend   = (gpu_re | gpu_we) & ~gpu_rdy_q;
    assign len_ok     = disp_len != 5'd0 && disp_len <= 5'(BURST_MAX);
    assign grant      = state_q == IDLE && disp_req && len_ok;
    assign last_word  = rem_q == 5'd1;
    assign gcnt_wrap  = gcnt_q == GC_W'(GUARD_WORDS - 1);
    assign guard_hit  = GUARD_EN && gcnt_wrap;
    assign rd_disp    = state_q == RD_S && !gpu_acc_q;
    assign rd_gpu     = state_q == RD_S && gpu_acc_q;
    assign burst_left = gpu_acc_q ? rem_q != 5'd0 : !last_word;

    always_comb begin
        state_d   = state_q;
        gpu_acc_d = gpu_acc_q;
        unique case (state_q)
            IDLE: begin
                if (disp_req) begin
                    state_d   = len_ok ? RD_A : IDLE;
                    gpu_acc_d = 1'b0;
                end else if (gpu_pend) begin
                    state_d   = gpu_we ? WR_A : RD_A;
                    gpu_acc_d = 1'b1;
                end
            end
            RD_A: state_d = RD_S;
            RD_S: begin
                if (!gpu_acc_q && gpu_pend && (last_word || guard_hit)) begin
                    state_d   = gpu_we ? WR_A : RD_A;
                    gpu_acc_d = 1'b1;
                end else begin
                    state_d   = burst_left ? RD_A : IDLE;
                    gpu_acc_d = 1'b0;
                end
            end
            WR_A: state_d = WR_P;
            WR_P: state_d = WR_H;
            WR_H: begin
                state_d   = rem_q != 5'd0 ? RD_A : IDLE;
                gpu_acc_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // every access begins with RD_A or WR_A; that is where its address and data are captured
    assign start   = state_d == RD_A || state_d == WR_A;
    assign dsrc    = grant ? disp_addr : dptr_q;
    assign addr_d  = !start ? addr_q : gpu_acc_d ? gpu_addr : dsrc;
    assign dptr_d  = start && !gpu_acc_d ? dsrc + 1'b1 : dptr_q;
    assign rem_d   = grant ? disp_len : rd_disp ? rem_q - 1'b1 : rem_q;
    assign gcnt_d  = grant ? '0 : rd_disp ? (gcnt_wrap ? '0 : gcnt_q + 1'b1) : gcnt_q;
    assign wdata_d = state_d == WR_A && state_q != WR_A ? gpu_wdata : wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            dptr_q       <= '0;
            rem_q        <= '0;
            gcnt_q       <= '0;
            gpu_acc_q    <= 1'b0;
            wdata_q      <= '0;
            disp_data_q  <= '0;
            gpu_rdata_q  <= '0;
            disp_valid_q <= 1'b0;
            disp_done_q  <= 1'b0;
            gpu_rdy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            dptr_q       <= dptr_d;
            rem_q        <= rem_d;
            gcnt_q       <= gcnt_d;
            gpu_acc_q    <= gpu_acc_d;
            wdata_q      <= wdata_d;
            disp_data_q  <= rd_disp ? sram_dq_in : disp_data_q;
            gpu_rdata_q  <= rd_gpu ? sram_dq_in : gpu_rdata_q;
            disp_valid_q <= rd_disp;
            disp_done_q  <= (rd_disp && last_word) || (state_q == IDLE && disp_req && !len_ok);
            gpu_rdy_q    <= rd_gpu || state_q == WR_P;
        end
    end

    always_comb begin
        sram_ce_n  = state_q == IDLE;
        sram_lb_n  = state_q == IDLE;
        sram_ub_n  = state_q == IDLE;
        sram_oe_n  = !(state_q == RD_A || state_q == RD_S);
        sram_we_n  = state_q != WR_P;
        sram_dq_oe = state_q == WR_A || state_q == WR_P || state_q == WR_H;
    end

    assign sram_addr   = {{(20-ADDR_W){1'b0}}, addr_q};
    assign sram_dq_out = wdata_q;
    assign disp_data   = disp_data_q;
    assign disp_valid  = disp_valid_q;
    assign disp_done   = disp_done_q;
    assign gpu_rdata   = gpu_rdata_q;
    assign gpu_rdy     = gpu_rdy_q;
endmodule
